alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares a single N-bit ALU datapath between NREQ independent requesters.
- Each requester issues an ALU command (opa, opb, opcode) with a valid/ready handshake.
- The block grants requesters round-robin, registers the operands, executes the operation, and returns the result tagged with the requester ID on one response channel with valid/ready.
- Sits between requester blocks (sequencers, DSP control) and the shared arithmetic resource.

Parameters:
- N, 8, operand and result width in bits.
- NREQ, 4, number of requesters; must be at least 2.
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_opa  in  NREQ*N  operand A, requester i at bits [i*N +: N].
- req_opb  in  NREQ*N  operand B, same packing as req_opa.
- req_opcode  in  NREQ*3  opcode, requester i at bits [i*3 +: 3].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that issued the command.
- rsp_data  out  N  result.
- rsp_err  out  1  opcode was illegal (5..7).

Behaviour:
- Opcodes (from package):
  - ADD=0: opa+opb mod 2^N.
  - SUB=1: opa-opb mod 2^N (two's complement wrap).
  - AND=2: opa&opb.
  - OR=3: opa|opb.
  - NOT=4: ~opa.
  - 5..7 illegal: rsp_data=0, rsp_err=1.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any req_valid is high, the arbiter picks a winner w. req_ready[w] is high in the same cycle (combinational from req_valid and the pointer, gated by state==IDLE).
  - On the edge, the block captures opa/opb/opcode and w, moves to EXEC, and sets the pointer to (w+1) mod NREQ.
  - If no req_valid is high, the FSM stays in IDLE and the pointer is unchanged.
- Round robin: search starts at the pointer index, ascending with wrap-around. Pointer reset value is 0.
- EXEC (one cycle): the operation is computed from the captured registers and the result is registered into rsp_data/rsp_err/rsp_id. Next state is RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable until the handshake.
  - rsp_valid&&rsp_ready moves the FSM to IDLE.
  - With rsp_ready low the FSM stalls indefinitely and all req_ready stay low.
- Latency and throughput:
  - Command accepted at edge T gives rsp_valid high from cycle T+2.
  - Peak throughput is one command per 3 cycles (rsp_ready tied high).
- req_ready is low in EXEC and RESP. A requester holds its command until it sees ready.
- A requester dropping valid before it is granted is legal; it is simply not granted.
- Reset:
  - rst high at any edge, including mid-EXEC or mid-RESP, forces IDLE, pointer=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - Any in-flight command is discarded with no response.
  - req_ready is 0 while rst is high.
- rsp_valid is registered (state==RESP). Outputs have no combinational path from rsp_ready.

Decomposition:
- Package alu_share_pkg holds:
  - opcode localparams (OP_ADD..OP_NOT, OPW=3)
  - the FSM state enum (ST_IDLE, ST_EXEC, ST_RESP)
  - a function alu_op(opa, opb, opcode) returning {err, result}.
- Sub-module rr_arbiter #(NREQ):
  - inputs: req, pointer, enable.
  - outputs: one-hot grant and binary grant index.
  - purely combinational.
- The top level holds the FSM, the pointer, the operand/result registers and the operand mux.

Test Plan:
- Single request: N=8, req0 ADD opa=8'hF0 opb=8'h20, rsp_ready=1 -> req_ready[0] in the accept cycle; 2 cycles later rsp_valid=1, rsp_data=8'h10, rsp_id=0, rsp_err=0; back in IDLE the following cycle.
- Wrap and ops: req1 SUB 8'h05-8'h07 -> rsp_data=8'hFE. NOT opa=8'h5A -> 8'hA5. AND 8'hCC&8'hAA -> 8'h88. OR -> 8'hEE.
- Fairness: all 4 requesters valid continuously with rsp_ready=1 -> grants in order 0,1,2,3,0,1, one every 3 cycles; rsp_id sequence matches.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; req_ready all 0. Raising rsp_ready completes the response, and the next grant occurs in the following cycle.
- Illegal opcode: req2 opcode=3'd6 -> rsp_err=1, rsp_data=0, rsp_id=2. A following legal command gives rsp_err=0.
- Reset mid-operation: assert rst during EXEC -> next cycle rsp_valid=0, pointer=0. The lost command produces no response. After release with req3 and req0 valid, req0 is granted first.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Shared definitions for the time-multiplexed ALU: opcodes, FSM states and the
// width-agnostic operation function used by the top level.
package alu_share_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'd0;
  localparam logic [OPW-1:0] OP_SUB = 3'd1;
  localparam logic [OPW-1:0] OP_AND = 3'd2;
  localparam logic [OPW-1:0] OP_OR  = 3'd3;
  localparam logic [OPW-1:0] OP_NOT = 3'd4;

  // Widest operand the helper supports; callers zero-extend and keep the low N bits.
  localparam int ALU_MAXW = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  // Returns {err, result}; modular arithmetic truncates correctly to any narrower width.
  function automatic logic [ALU_MAXW:0] alu_op(input logic [ALU_MAXW-1:0] opa,
                                               input logic [ALU_MAXW-1:0] opb,
                                               input logic [OPW-1:0]      opcode);
    logic [ALU_MAXW-1:0] res;
    logic                err;
    res = '0;
    err = 1'b0;
    case (opcode)
      OP_ADD:  res = opa + opb;
      OP_SUB:  res = opa - opb;
      OP_AND:  res = opa & opb;
      OP_OR:   res = opa | opb;
      OP_NOT:  res = ~opa;
      default: err = 1'b1;
    endcase
    return {err, res};
  endfunction

endpackage

// File: rtl/alu_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: highest priority at 'pointer', ascending
// with wrap-around. No grant is produced while 'enable' is low.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  pointer,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic           found;

  // Walk the requesters starting at the pointer; the first active one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, pointer} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one N-bit ALU between NREQ requesters: round-robin accept, one execute
// cycle, then a held response tagged with the requester index.
module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_opa,
  input  logic [NREQ*N-1:0] req_opb,
  input  logic [NREQ*3-1:0] req_opcode,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_data,
  output logic              rsp_err
);

  state_t state, state_next;

  logic [IDW-1:0]  pointer;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            arb_en;
  logic            accept;

  logic [N-1:0]    sel_opa, sel_opb;
  logic [OPW-1:0]  sel_op;
  logic [N-1:0]    opa_q, opb_q;
  logic [OPW-1:0]  op_q;
  logic [IDW-1:0]  id_q;
  logic [ALU_MAXW:0] alu_full;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .pointer   (pointer),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Grants only exist in IDLE outside reset, so req_ready is never high elsewhere.
  always_comb begin
    arb_en    = (state == ST_IDLE) && !rst;
    accept    = |grant;
    req_ready = grant;
    rsp_valid = (state == ST_RESP);
  end

  // One-hot operand mux driven directly by the arbiter grant.
  always_comb begin
    sel_opa = '0;
    sel_opb = '0;
    sel_op  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_opa = req_opa[i*N +: N];
        sel_opb = req_opb[i*N +: N];
        sel_op  = req_opcode[i*3 +: 3];
      end
    end
  end

  always_comb begin
    alu_full = alu_op(ALU_MAXW'(opa_q), ALU_MAXW'(opb_q), op_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pointer  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      id_q     <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        opa_q   <= sel_opa;
        opb_q   <= sel_opb;
        op_q    <= sel_op;
        id_q    <= grant_idx;
        pointer <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
      end
      if (state == ST_EXEC) begin
        rsp_data <= N'(alu_full);
        rsp_err  <= alu_full[ALU_MAXW];
        rsp_id   <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb: latency, opcodes, fairness,
// backpressure, illegal opcodes and reset during execution.
module tb_alu_share_arb;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_opa;
  logic [NREQ*N-1:0] req_opb;
  logic [NREQ*3-1:0] req_opcode;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_data;
  logic              rsp_err;

  int checks   = 0;
  int failures = 0;

  alu_share_arb #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opa    (req_opa),
    .req_opb    (req_opb),
    .req_opcode (req_opcode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    req_opa[id*8 +: 8]    = a;
    req_opb[id*8 +: 8]    = b;
    req_opcode[id*3 +: 3] = op;
    req_valid[id]         = 1'b1;
  endtask

  // Issues one command from a single requester with rsp_ready high and samples each phase.
  task automatic run_cmd(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, output logic [3:0] rdy,
                         output logic vexec, output logic vresp, output logic [7:0] data,
                         output logic [1:0] rid, output logic err, output logic vafter);
    rsp_ready = 1'b1;
    req_valid = '0;
    set_req(id, a, b, op);
    #1;
    rdy = req_ready;
    tick();
    req_valid = '0;
    vexec = rsp_valid;
    tick();
    vresp = rsp_valid;
    data  = rsp_data;
    rid   = rsp_id;
    err   = rsp_err;
    tick();
    vafter = rsp_valid;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    rsp_ready  = 1'b1;
    req_opa    = '0;
    req_opb    = '0;
    req_opcode = '0;
    req_valid  = 4'hF;
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ready got=%b want=0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h want=00", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("[TB] FAIL reset_id got=%0d want=0", rsp_id); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b want=0", rsp_err); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL reset_first_grant got=%b want=0001", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_req(0, 8'hF0, 8'h20, 3'd0);
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL single_ready got=%b want=0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_exec_valid got=%b want=0", rsp_valid); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL single_exec_ready got=%b want=0000", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_rsp_valid got=%b want=1", rsp_valid); end
    checks++; if (rsp_data !== 8'h10) begin failures++; $display("[TB] FAIL single_data got=%h want=10", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("[TB] FAIL single_id got=%0d want=0", rsp_id); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL single_err got=%b want=0", rsp_err); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_idle_valid got=%b want=0", rsp_valid); end
    // Pointer has moved past requester 0; requester 1 withdraws before the edge.
    set_req(1, 8'h00, 8'h00, 3'd0);
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL single_next_ptr got=%b want=0010", req_ready); end
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL withdraw_no_exec got=%b want=0", rsp_valid); end
  endtask

  int          op_id[6]   = '{1, 3, 0, 2, 1, 0};
  logic [7:0]  op_a[6]    = '{8'h05, 8'h5A, 8'hCC, 8'hCC, 8'hFF, 8'h00};
  logic [7:0]  op_b[6]    = '{8'h07, 8'h00, 8'hAA, 8'hAA, 8'h01, 8'h01};
  logic [2:0]  op_code[6] = '{3'd1, 3'd4, 3'd2, 3'd3, 3'd0, 3'd1};
  logic [7:0]  op_exp[6]  = '{8'hFE, 8'hA5, 8'h88, 8'hEE, 8'h00, 8'hFF};

  task automatic test_ops();
    logic [3:0] rdy;
    logic       vexec, vresp, err, vafter;
    logic [7:0] data;
    logic [1:0] rid;
    for (int t = 0; t < 6; t++) begin
      run_cmd(op_id[t], op_a[t], op_b[t], op_code[t], rdy, vexec, vresp, data, rid, err, vafter);
      checks++; if (rdy !== 4'(1 << op_id[t])) begin failures++; $display("[TB] FAIL ops%0d_ready got=%b want=%b", t, rdy, 4'(1 << op_id[t])); end
      checks++; if (vexec !== 1'b0 || vresp !== 1'b1 || vafter !== 1'b0) begin failures++; $display("[TB] FAIL ops%0d_timing got=%b%b%b want=010", t, vexec, vresp, vafter); end
      checks++; if (data !== op_exp[t]) begin failures++; $display("[TB] FAIL ops%0d_data got=%h want=%h", t, data, op_exp[t]); end
      checks++; if (rid !== 2'(op_id[t])) begin failures++; $display("[TB] FAIL ops%0d_id got=%0d want=%0d", t, rid, op_id[t]); end
      checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL ops%0d_err got=%b want=0", t, err); end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] rdy;
    logic       vexec, vresp, err, vafter;
    logic [7:0] data;
    logic [1:0] rid;
    run_cmd(2, 8'h12, 8'h34, 3'd6, rdy, vexec, vresp, data, rid, err, vafter);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL illegal6_err got=%b want=1", err); end
    checks++; if (data !== 8'h00) begin failures++; $display("[TB] FAIL illegal6_data got=%h want=00", data); end
    checks++; if (rid !== 2'd2) begin failures++; $display("[TB] FAIL illegal6_id got=%0d want=2", rid); end
    run_cmd(2, 8'hFF, 8'hFF, 3'd5, rdy, vexec, vresp, data, rid, err, vafter);
    checks++; if (err !== 1'b1 || data !== 8'h00) begin failures++; $display("[TB] FAIL illegal5 got err=%b data=%h want err=1 data=00", err, data); end
    run_cmd(2, 8'h01, 8'h02, 3'd0, rdy, vexec, vresp, data, rid, err, vafter);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL legal_after_err got=%b want=0", err); end
    checks++; if (data !== 8'h03) begin failures++; $display("[TB] FAIL legal_after_data got=%h want=03", data); end
    run_cmd(3, 8'hAB, 8'hCD, 3'd7, rdy, vexec, vresp, data, rid, err, vafter);
    checks++; if (err !== 1'b1 || data !== 8'h00 || rid !== 2'd3) begin failures++; $display("[TB] FAIL illegal7 got err=%b data=%h id=%0d want 1/00/3", err, data, rid); end
  endtask

  logic [7:0] fair_exp[4] = '{8'h01, 8'h11, 8'h21, 8'h31};

  task automatic test_fairness();
    logic [3:0] want;
    int         slot;
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(16 * i), 8'h01, 3'd0);
    for (int c = 0; c < 18; c++) begin
      #1;
      slot = (c / 3) % 4;
      want = (c % 3 == 0) ? 4'(1 << slot) : 4'b0000;
      checks++; if (req_ready !== want) begin failures++; $display("[TB] FAIL fair_c%0d_ready got=%b want=%b", c, req_ready, want); end
      if (c % 3 == 2) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(slot)) begin failures++; $display("[TB] FAIL fair_c%0d_rsp got v=%b id=%0d want v=1 id=%0d", c, rsp_valid, rsp_id, slot); end
        checks++; if (rsp_data !== fair_exp[slot]) begin failures++; $display("[TB] FAIL fair_c%0d_data got=%h want=%h", c, rsp_data, fair_exp[slot]); end
      end
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    reset_dut();
    rsp_ready = 1'b0;
    set_req(2, 8'h0F, 8'hF0, 3'd3);
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("[TB] FAIL bp_ready got=%b want=0100", req_ready); end
    tick();
    req_valid = '0;
    tick();
    set_req(0, 8'h01, 8'h01, 3'd0);
    set_req(1, 8'h02, 8'h02, 3'd0);
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF || rsp_id !== 2'd2 || rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL bp_hold_c%0d got v=%b d=%h id=%0d e=%b want 1/FF/2/0", c, rsp_valid, rsp_data, rsp_id, rsp_err); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL bp_stall_ready_c%0d got=%b want=0000", c, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_valid got=%b want=1", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_done_valid got=%b want=0", rsp_valid); end
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL bp_next_grant got=%b want=0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h02) begin failures++; $display("[TB] FAIL bp_next_rsp got v=%b id=%0d d=%h want 1/0/02", rsp_valid, rsp_id, rsp_data); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    set_req(1, 8'h11, 8'h22, 3'd0);
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL rmid_ready got=%b want=0010", req_ready); end
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin failures++; $display("[TB] FAIL rmid_cleared got v=%b d=%h id=%0d want 0/00/0", rsp_valid, rsp_data, rsp_id); end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rmid_lost_c%0d got=%b want=0", c, rsp_valid); end
    end
    set_req(3, 8'h03, 8'h00, 3'd0);
    set_req(0, 8'h04, 8'h00, 3'd0);
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL rmid_ptr_reset got=%b want=0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h04) begin failures++; $display("[TB] FAIL rmid_rsp got v=%b id=%0d d=%h want 1/0/04", rsp_valid, rsp_id, rsp_data); end
    tick();
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("[TB] FAIL rmid_second got=%b want=1000", req_ready); end
    req_valid = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_ops();
    test_illegal();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
